hrm_ctrl_fsm: RTL and testbench
===============================

// Module: hrm_ctrl_fsm
// PURPOSE
//  Parametrised next-generation HRM CPU control FSM. Decodes opcode/indirect bits of the IR and sequences the datapath with Moore strobes.
//  New over the previous unit:
//   - configurable instruction width
//   - INBOX/OUTBOX stall watchdog with a FAULT state
//   - edge-qualified single-step debug
//   - optional retired-instruction counter
// PARAMETERS
//  INSTR_W    8     IR width (>=5); opcode = INSTR[INSTR_W-1 -: 4], indirect = INSTR[INSTR_W-5]
//  STALL_MAX  1023  max consecutive DECODE cycles stalled on inEmpty/outFull before FAULT; 0 = watchdog off
//  CNT_W      16    width of retired counter
// PORTS
//  clk       in   1        system clock, rising edge
//  i_rst     in   1        reset, asynchronous, active-high
//  INSTR     in   INSTR_W  instruction register contents
//  inEmpty   in   1        inbox FIFO empty
//  outFull   in   1        outbox FIFO full
//  debug     in   1        single-step mode enable
//  nxtInstr  in   1        step request (level; rising edge used)
//  busy      in   1        WAIT timer running
//  ctl       out  18       strobes {wIR,muxR[1:0],wR,srcA,wM,wAR,aluCtl[2:0],wPC,rIn,wO,ijump,branch,rst,halt,enT}, MSB first
//  fault     out  1        sticky: watchdog expired or illegal state reached
//  retired   out  CNT_W    count of retired instructions (0 unless HRM_PERF_CNT_EN)
// BEHAVIOUR
//  - i_rst asserted (async):
//    - state=RESET; ctl = only rst=1; fault=0; stall counter=0; retired=0; step-edge register=0.
//  - States and Moore strobes (unlisted strobes 0):
//    - RESET: rst
//    - FETCH_I, DECODE, FETCH_O, READMEM, READMEM2, WAIT_KEY: none
//    - LOAD_IR: wIR
//    - INBOX: rIn,wR,muxR=00
//    - OUTBOX: wO
//    - INCPC, INCPC2: wPC
//    - COPYFROM: wR,muxR=01
//    - SET: wR,muxR=10
//    - ADD: wR,muxR=11,alu=000
//    - SUB: wR,muxR=11,alu=001
//    - BUMPP: wR,muxR=11,alu=010
//    - BUMPN: wR,muxR=11,alu=011
//    - COPYTO: wM
//    - LOAD_AR: wAR
//    - LOAD_AR2: wAR,srcA
//    - JUMP: branch,ijump,wPC
//    - JUMPZ: branch,wPC,alu=000
//    - JUMPN: branch,wPC,alu=100
//    - INIT_TIMER: enT
//    - HALT, FAULT: halt
//  - Transitions:
//    - RESET->FETCH_I
//    - FETCH_I->(debug?WAIT_KEY:LOAD_IR)
//    - WAIT_KEY->LOAD_IR on nxtInstr rising edge only; holding nxtInstr high steps exactly once
//    - LOAD_IR->DECODE
//    - DECODE on opcode:
//      - INBOX(0): stay while inEmpty, else ->INBOX
//      - OUTBOX(1): stay while outFull, else ->OUTBOX
//      - NOP1/NOP2(B,C)->INCPC
//      - HALT(F)->HALT
//      - others->INCPC2
//    - INCPC2->FETCH_O
//    - FETCH_O on opcode: JUMP/JUMPZ/JUMPN(8,9,A)->same-named state; SET(E)->SET; WAIT(D)->INIT_TIMER; else->LOAD_AR
//    - LOAD_AR: COPYTO & !indirect->COPYTO; indirect->READMEM2; else->READMEM
//    - READMEM2->LOAD_AR2
//    - LOAD_AR2: COPYTO->COPYTO, else->READMEM
//    - READMEM on opcode: COPYFROM/ADD/SUB/BUMPP/BUMPN->same-named state; other->HALT
//    - BUMPP, BUMPN->COPYTO
//    - INBOX, OUTBOX, COPYFROM, COPYTO, ADD, SUB, SET->INCPC
//    - INIT_TIMER->WAIT_TIMER; WAIT_TIMER stays while busy, else ->INCPC
//    - INCPC, JUMP, JUMPZ, JUMPN->FETCH_I
//    - HALT, FAULT: terminal until i_rst
//  - Watchdog:
//    - counter increments each cycle DECODE self-loops on a stall; cleared in every other state.
//    - the stall cycle on which counter==STALL_MAX-1 goes to FAULT instead of DECODE. Data arriving in that same cycle is ignored; stall has priority.
//  - fault:
//    - set on entry to FAULT or on any unencoded state code (next state forced to FAULT); held until reset.
//  - Reset mid-instruction: aborts immediately; no partial strobes after the asynchronous edge.
// CONFIGURATION
//  HRM_PERF_CNT_EN defined:
//   - retired += 1 (wraps at 2^CNT_W) on each transition into FETCH_I from INCPC/JUMP/JUMPZ/JUMPN
//   - HALT counts when HALT is entered
//  Undefined: retired tied to 0, no counter flops.
// STRUCTURE
//  - Package hrm_ctrl_pkg (`include header): 5-bit state codes, 4-bit opcode constants, ctl bit indices, muxR/aluCtl encodings.
//  - One sub-module: hrm_stall_wdog, which holds the counter and emits expire.
//  - Outputs: one combinational Moore decode of state. Next-state: one combinational block. State: one async-reset register.
// TESTING
//  - Reset then INSTR=8'h00 with inEmpty=0 -> RESET,FETCH_I,LOAD_IR,DECODE,INBOX,INCPC; rIn&wR in INBOX, wPC in INCPC.
//  - INSTR=8'h48 (ADD indirect) -> ...,INCPC2,FETCH_O,LOAD_AR,READMEM2,LOAD_AR2,READMEM,ADD,INCPC; srcA=1 only in LOAD_AR2.
//  - STALL_MAX=4, INSTR=8'h10, outFull=1 held -> FAULT after exactly 4 DECODE cycles; halt=1, fault=1 until i_rst.
//  - debug=1, nxtInstr held high 10 cycles -> exactly one LOAD_IR; next step only after nxtInstr low then high.
//  - INSTR=8'hD0, busy high 5 cycles -> enT one cycle, WAIT_TIMER until busy=0, then INCPC.
//  - HRM_PERF_CNT_EN, 3 NOPs (8'hB0) then HALT (8'hF0) -> retired=4; async i_rst mid-DECODE -> retired=0, rst strobe, state RESET.

Source files
------------

// File: rtl/hrm_ctrl_fsm_pkg.sv
// Shared encodings for the HRM control FSM: state codes, opcodes, ctl bit indices, muxR/aluCtl values.
package hrm_ctrl_pkg;

  localparam logic [4:0] S_RESET      = 5'd0;
  localparam logic [4:0] S_FETCH_I    = 5'd1;
  localparam logic [4:0] S_WAIT_KEY   = 5'd2;
  localparam logic [4:0] S_LOAD_IR    = 5'd3;
  localparam logic [4:0] S_DECODE     = 5'd4;
  localparam logic [4:0] S_INBOX      = 5'd5;
  localparam logic [4:0] S_OUTBOX     = 5'd6;
  localparam logic [4:0] S_INCPC      = 5'd7;
  localparam logic [4:0] S_INCPC2     = 5'd8;
  localparam logic [4:0] S_FETCH_O    = 5'd9;
  localparam logic [4:0] S_LOAD_AR    = 5'd10;
  localparam logic [4:0] S_READMEM    = 5'd11;
  localparam logic [4:0] S_READMEM2   = 5'd12;
  localparam logic [4:0] S_LOAD_AR2   = 5'd13;
  localparam logic [4:0] S_COPYFROM   = 5'd14;
  localparam logic [4:0] S_COPYTO     = 5'd15;
  localparam logic [4:0] S_SET        = 5'd16;
  localparam logic [4:0] S_ADD        = 5'd17;
  localparam logic [4:0] S_SUB        = 5'd18;
  localparam logic [4:0] S_BUMPP      = 5'd19;
  localparam logic [4:0] S_BUMPN      = 5'd20;
  localparam logic [4:0] S_JUMP       = 5'd21;
  localparam logic [4:0] S_JUMPZ      = 5'd22;
  localparam logic [4:0] S_JUMPN      = 5'd23;
  localparam logic [4:0] S_INIT_TIMER = 5'd24;
  localparam logic [4:0] S_WAIT_TIMER = 5'd25;
  localparam logic [4:0] S_HALT       = 5'd26;
  localparam logic [4:0] S_FAULT      = 5'd27;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPP    = 4'h6;
  localparam logic [3:0] OP_BUMPN    = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_NOP1     = 4'hB;
  localparam logic [3:0] OP_NOP2     = 4'hC;
  localparam logic [3:0] OP_WAIT     = 4'hD;
  localparam logic [3:0] OP_SET      = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam int unsigned CTL_WIR    = 17;
  localparam int unsigned CTL_MUXR_H = 16;
  localparam int unsigned CTL_MUXR_L = 15;
  localparam int unsigned CTL_WR     = 14;
  localparam int unsigned CTL_SRCA   = 13;
  localparam int unsigned CTL_WM     = 12;
  localparam int unsigned CTL_WAR    = 11;
  localparam int unsigned CTL_ALU_H  = 10;
  localparam int unsigned CTL_ALU_L  = 8;
  localparam int unsigned CTL_WPC    = 7;
  localparam int unsigned CTL_RIN    = 6;
  localparam int unsigned CTL_WO     = 5;
  localparam int unsigned CTL_IJUMP  = 4;
  localparam int unsigned CTL_BRANCH = 3;
  localparam int unsigned CTL_RST    = 2;
  localparam int unsigned CTL_HALT   = 1;
  localparam int unsigned CTL_ENT    = 0;

  localparam logic [1:0] MUXR_IN    = 2'b00;
  localparam logic [1:0] MUXR_MEM   = 2'b01;
  localparam logic [1:0] MUXR_CONST = 2'b10;
  localparam logic [1:0] MUXR_ALU   = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INC = 3'b010;
  localparam logic [2:0] ALU_DEC = 3'b011;
  localparam logic [2:0] ALU_NEG = 3'b100;

endpackage

// File: rtl/hrm_ctrl_fsm_wdog.sv
// Stall watchdog: counts consecutive DECODE stall cycles and flags the one that must divert to FAULT.
module hrm_stall_wdog #(
  parameter int unsigned STALL_MAX = 1023
) (
  input  logic clk,
  input  logic i_rst,
  input  logic stall,
  output logic expire
);

  localparam int unsigned CW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX);
  localparam logic [CW-1:0] LAST = CW'((STALL_MAX == 0) ? 0 : STALL_MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)
      cnt <= '0;
    else if (stall && !expire)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

  // STALL_MAX of zero disables expiry; the counter then just wraps harmlessly
  assign expire = (STALL_MAX != 0) && stall && (cnt == LAST);

endmodule

// File: rtl/hrm_ctrl_fsm.sv
// HRM CPU control FSM with stall watchdog and single-step debug.
// Define HRM_PERF_CNT_EN to build the retired-instruction counter.
module hrm_ctrl_fsm
  import hrm_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W   = 8,
  parameter int unsigned STALL_MAX = 1023,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               inEmpty,
  input  logic               outFull,
  input  logic               debug,
  input  logic               nxtInstr,
  input  logic               busy,
  output logic [17:0]        ctl,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  logic [4:0] state, nxt;
  logic [3:0] op;
  logic       ind, stall, expire, nxt_q, step;
  logic       unused_instr;

  assign op           = INSTR[INSTR_W-1 -: 4];
  assign ind          = INSTR[INSTR_W-5];
  assign unused_instr = ^INSTR;
  assign step         = nxtInstr & ~nxt_q;
  assign stall        = (state == S_DECODE) &&
                        (((op == OP_INBOX) && inEmpty) || ((op == OP_OUTBOX) && outFull));

  hrm_stall_wdog #(.STALL_MAX(STALL_MAX)) u_wdog (
    .clk    (clk),
    .i_rst  (i_rst),
    .stall  (stall),
    .expire (expire)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_RESET:    nxt = S_FETCH_I;
      S_FETCH_I:  nxt = debug ? S_WAIT_KEY : S_LOAD_IR;
      S_WAIT_KEY: nxt = step ? S_LOAD_IR : S_WAIT_KEY;
      S_LOAD_IR:  nxt = S_DECODE;
      S_DECODE: begin
        if (stall)
          nxt = expire ? S_FAULT : S_DECODE;
        else begin
          case (op)
            OP_INBOX:          nxt = S_INBOX;
            OP_OUTBOX:         nxt = S_OUTBOX;
            OP_NOP1, OP_NOP2:  nxt = S_INCPC;
            OP_HALT:           nxt = S_HALT;
            default:           nxt = S_INCPC2;
          endcase
        end
      end
      S_INCPC2:   nxt = S_FETCH_O;
      S_FETCH_O: begin
        case (op)
          OP_JUMP:  nxt = S_JUMP;
          OP_JUMPZ: nxt = S_JUMPZ;
          OP_JUMPN: nxt = S_JUMPN;
          OP_SET:   nxt = S_SET;
          OP_WAIT:  nxt = S_INIT_TIMER;
          default:  nxt = S_LOAD_AR;
        endcase
      end
      S_LOAD_AR: begin
        if ((op == OP_COPYTO) && !ind) nxt = S_COPYTO;
        else if (ind)                  nxt = S_READMEM2;
        else                           nxt = S_READMEM;
      end
      S_READMEM2: nxt = S_LOAD_AR2;
      S_LOAD_AR2: nxt = (op == OP_COPYTO) ? S_COPYTO : S_READMEM;
      S_READMEM: begin
        case (op)
          OP_COPYFROM: nxt = S_COPYFROM;
          OP_ADD:      nxt = S_ADD;
          OP_SUB:      nxt = S_SUB;
          OP_BUMPP:    nxt = S_BUMPP;
          OP_BUMPN:    nxt = S_BUMPN;
          default:     nxt = S_HALT;
        endcase
      end
      S_BUMPP, S_BUMPN:                         nxt = S_COPYTO;
      S_INBOX, S_OUTBOX, S_COPYFROM, S_COPYTO,
      S_ADD, S_SUB, S_SET:                      nxt = S_INCPC;
      S_INIT_TIMER:                             nxt = S_WAIT_TIMER;
      S_WAIT_TIMER:                             nxt = busy ? S_WAIT_TIMER : S_INCPC;
      S_INCPC, S_JUMP, S_JUMPZ, S_JUMPN:        nxt = S_FETCH_I;
      S_HALT:                                   nxt = S_HALT;
      S_FAULT:                                  nxt = S_FAULT;
      default:                                  nxt = S_FAULT;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_RESET:    ctl[CTL_RST] = 1'b1;
      S_LOAD_IR:  ctl[CTL_WIR] = 1'b1;
      S_INBOX:    begin ctl[CTL_RIN] = 1'b1; ctl[CTL_WR] = 1'b1; ctl[CTL_MUXR_H:CTL_MUXR_L] = MUXR_IN; end
      S_OUTBOX:   ctl[CTL_WO] = 1'b1;
      S_INCPC, S_INCPC2: ctl[CTL_WPC] = 1'b1;
      S_COPYFROM: begin ctl[CTL_WR] = 1'b1; ctl[CTL_MUXR_H:CTL_MUXR_L] = MUXR_MEM; end
      S_SET:      begin ctl[CTL_WR] = 1'b1; ctl[CTL_MUXR_H:CTL_MUXR_L] = MUXR_CONST; end
      S_ADD:      begin ctl[CTL_WR] = 1'b1; ctl[CTL_MUXR_H:CTL_MUXR_L] = MUXR_ALU; ctl[CTL_ALU_H:CTL_ALU_L] = ALU_ADD; end
      S_SUB:      begin ctl[CTL_WR] = 1'b1; ctl[CTL_MUXR_H:CTL_MUXR_L] = MUXR_ALU; ctl[CTL_ALU_H:CTL_ALU_L] = ALU_SUB; end
      S_BUMPP:    begin ctl[CTL_WR] = 1'b1; ctl[CTL_MUXR_H:CTL_MUXR_L] = MUXR_ALU; ctl[CTL_ALU_H:CTL_ALU_L] = ALU_INC; end
      S_BUMPN:    begin ctl[CTL_WR] = 1'b1; ctl[CTL_MUXR_H:CTL_MUXR_L] = MUXR_ALU; ctl[CTL_ALU_H:CTL_ALU_L] = ALU_DEC; end
      S_COPYTO:   ctl[CTL_WM] = 1'b1;
      S_LOAD_AR:  ctl[CTL_WAR] = 1'b1;
      S_LOAD_AR2: begin ctl[CTL_WAR] = 1'b1; ctl[CTL_SRCA] = 1'b1; end
      S_JUMP:     begin ctl[CTL_BRANCH] = 1'b1; ctl[CTL_IJUMP] = 1'b1; ctl[CTL_WPC] = 1'b1; end
      S_JUMPZ:    begin ctl[CTL_BRANCH] = 1'b1; ctl[CTL_WPC] = 1'b1; ctl[CTL_ALU_H:CTL_ALU_L] = ALU_ADD; end
      S_JUMPN:    begin ctl[CTL_BRANCH] = 1'b1; ctl[CTL_WPC] = 1'b1; ctl[CTL_ALU_H:CTL_ALU_L] = ALU_NEG; end
      S_INIT_TIMER: ctl[CTL_ENT] = 1'b1;
      S_HALT, S_FAULT: ctl[CTL_HALT] = 1'b1;
      default:    ctl = '0;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_RESET;
      nxt_q <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      nxt_q <= nxtInstr;
      fault <= fault | (nxt == S_FAULT);
    end
  end

`ifdef HRM_PERF_CNT_EN
  logic [CNT_W-1:0] ret_cnt;
  logic             retire;

  // HALT retires on entry; everything else retires on its return to FETCH_I
  assign retire = ((nxt == S_FETCH_I) &&
                   ((state == S_INCPC) || (state == S_JUMP) || (state == S_JUMPZ) || (state == S_JUMPN))) ||
                  ((nxt == S_HALT) && (state != S_HALT));

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)
      ret_cnt <= '0;
    else if (retire)
      ret_cnt <= ret_cnt + 1'b1;
  end

  assign retired = ret_cnt;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_hrm_ctrl_fsm.sv
// Directed bench for hrm_ctrl_fsm: per-cycle vector table plus hand sequences for step, watchdog and reset.
module tb_hrm_ctrl_fsm;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  INSTR;
  logic        inEmpty, outFull, debug, nxtInstr, busy;
  logic [17:0] ctl;
  logic        fault;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef HRM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [17:0] C_NONE  = 18'h00000;
  localparam logic [17:0] C_RST   = 18'h00004;
  localparam logic [17:0] C_LDIR  = 18'h20000;
  localparam logic [17:0] C_INBOX = 18'h04040;
  localparam logic [17:0] C_OUTB  = 18'h00020;
  localparam logic [17:0] C_WPC   = 18'h00080;
  localparam logic [17:0] C_SET   = 18'h14000;
  localparam logic [17:0] C_ADD   = 18'h1C000;
  localparam logic [17:0] C_BUMPP = 18'h1C200;
  localparam logic [17:0] C_CPTO  = 18'h01000;
  localparam logic [17:0] C_LDAR  = 18'h00800;
  localparam logic [17:0] C_LDAR2 = 18'h02800;
  localparam logic [17:0] C_JUMP  = 18'h00098;
  localparam logic [17:0] C_JUMPN = 18'h00488;
  localparam logic [17:0] C_ENT   = 18'h00001;
  localparam logic [17:0] C_HALT  = 18'h00002;

  hrm_ctrl_fsm #(.INSTR_W(8), .STALL_MAX(4), .CNT_W(16)) dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .INSTR    (INSTR),
    .inEmpty  (inEmpty),
    .outFull  (outFull),
    .debug    (debug),
    .nxtInstr (nxtInstr),
    .busy     (busy),
    .ctl      (ctl),
    .fault    (fault),
    .retired  (retired)
  );

  typedef struct {
    logic [7:0]  instr;
    logic        ie;
    logic        oful;
    logic        bz;
    logic [17:0] ctl;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] er(input int n);
    return PERF ? n : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic p(input logic [7:0] i, input logic ie, input logic of_, input logic bz, input logic [17:0] c);
    vec_t x;
    x.instr = i; x.ie = ie; x.oful = of_; x.bz = bz; x.ctl = c;
    vq.push_back(x);
  endtask

  // LOAD_IR, DECODE, INCPC2, FETCH_O for the two-word opcodes
  task automatic head2(input logic [7:0] i);
    p(i, 0, 0, 0, C_LDIR); p(i, 0, 0, 0, C_NONE); p(i, 0, 0, 0, C_WPC); p(i, 0, 0, 0, C_NONE);
  endtask

  initial begin
    int n;
    i_rst = 1'b1; INSTR = '0; inEmpty = 1'b0; outFull = 1'b0;
    debug = 1'b0; nxtInstr = 1'b0; busy = 1'b0;

    p(8'h00, 0, 0, 0, C_NONE);
    p(8'h00, 0, 0, 0, C_LDIR); p(8'h00, 0, 0, 0, C_NONE); p(8'h00, 0, 0, 0, C_INBOX);
    p(8'h00, 0, 0, 0, C_WPC);  p(8'h00, 0, 0, 0, C_NONE);
    head2(8'h48);
    p(8'h48, 0, 0, 0, C_LDAR); p(8'h48, 0, 0, 0, C_NONE); p(8'h48, 0, 0, 0, C_LDAR2);
    p(8'h48, 0, 0, 0, C_NONE); p(8'h48, 0, 0, 0, C_ADD);  p(8'h48, 0, 0, 0, C_WPC);
    p(8'h48, 0, 0, 0, C_NONE);
    p(8'h10, 0, 1, 0, C_LDIR); p(8'h10, 0, 1, 0, C_NONE);
    p(8'h10, 0, 1, 0, C_NONE); p(8'h10, 0, 1, 0, C_NONE); p(8'h10, 0, 1, 0, C_NONE);
    p(8'h10, 0, 0, 0, C_OUTB); p(8'h10, 0, 0, 0, C_WPC);  p(8'h10, 0, 0, 0, C_NONE);
    head2(8'hD0);
    p(8'hD0, 0, 0, 1, C_ENT);
    for (int k = 0; k < 5; k++) p(8'hD0, 0, 0, 1, C_NONE);
    p(8'hD0, 0, 0, 0, C_WPC);  p(8'hD0, 0, 0, 0, C_NONE);
    head2(8'h80);
    p(8'h80, 0, 0, 0, C_JUMP); p(8'h80, 0, 0, 0, C_NONE);
    head2(8'hA0);
    p(8'hA0, 0, 0, 0, C_JUMPN); p(8'hA0, 0, 0, 0, C_NONE);
    head2(8'h30);
    p(8'h30, 0, 0, 0, C_LDAR); p(8'h30, 0, 0, 0, C_CPTO); p(8'h30, 0, 0, 0, C_WPC);
    p(8'h30, 0, 0, 0, C_NONE);
    head2(8'h60);
    p(8'h60, 0, 0, 0, C_LDAR); p(8'h60, 0, 0, 0, C_NONE); p(8'h60, 0, 0, 0, C_BUMPP);
    p(8'h60, 0, 0, 0, C_CPTO); p(8'h60, 0, 0, 0, C_WPC);  p(8'h60, 0, 0, 0, C_NONE);
    head2(8'hE0);
    p(8'hE0, 0, 0, 0, C_SET);  p(8'hE0, 0, 0, 0, C_WPC);  p(8'hE0, 0, 0, 0, C_NONE);
    head2(8'h38);
    p(8'h38, 0, 0, 0, C_LDAR); p(8'h38, 0, 0, 0, C_NONE); p(8'h38, 0, 0, 0, C_LDAR2);
    p(8'h38, 0, 0, 0, C_CPTO); p(8'h38, 0, 0, 0, C_WPC);  p(8'h38, 0, 0, 0, C_NONE);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", ctl, C_RST);
    chk("reset_fault", fault, 0);
    chk("reset_retired", retired, 0);
    i_rst = 1'b0;

    foreach (vq[k]) begin
      INSTR = vq[k].instr; inEmpty = vq[k].ie; outFull = vq[k].oful; busy = vq[k].bz;
      tick;
      chk($sformatf("vec%0d_ctl", k), ctl, vq[k].ctl);
    end
    chk("table_fault", fault, 0);
    chk("table_retired", retired, er(10));

    debug = 1'b1; INSTR = 8'hB0;
    tick; chk("dbg_wait_key", ctl, C_NONE);
    tick; chk("dbg_hold", ctl, C_NONE);
    nxtInstr = 1'b1; n = 0;
    repeat (10) begin
      tick;
      if (ctl == C_LDIR) n++;
    end
    chk("dbg_one_step", n, 1);
    chk("dbg_parked", ctl, C_NONE);
    nxtInstr = 1'b0; tick; chk("dbg_low", ctl, C_NONE);
    nxtInstr = 1'b1; tick; chk("dbg_second_step", ctl, C_LDIR);
    debug = 1'b0; nxtInstr = 1'b0;
    tick; tick; chk("dbg_incpc", ctl, C_WPC);
    tick;

    INSTR = 8'h10; outFull = 1'b1;
    tick; chk("wd_load_ir", ctl, C_LDIR);
    tick;
    repeat (3) begin
      tick;
      chk("wd_stall_ctl", ctl, C_NONE);
      chk("wd_stall_fault", fault, 0);
    end
    tick;
    chk("wd_fault_ctl", ctl, C_HALT);
    chk("wd_fault_flag", fault, 1);
    outFull = 1'b0;
    repeat (4) tick;
    chk("wd_sticky_ctl", ctl, C_HALT);
    chk("wd_sticky_flag", fault, 1);
    i_rst = 1'b1; tick;
    chk("wd_reset_ctl", ctl, C_RST);
    chk("wd_reset_fault", fault, 0);

    i_rst = 1'b0; INSTR = 8'hB0;
    tick;
    repeat (12) tick;
    INSTR = 8'hF0;
    tick; tick; tick;
    chk("perf_halt_ctl", ctl, C_HALT);
    chk("perf_halt_fault", fault, 0);
    chk("perf_retired4", retired, er(4));
    repeat (3) tick;
    chk("perf_halt_stays", ctl, C_HALT);
    chk("perf_retired_stays", retired, er(4));

    i_rst = 1'b1; tick; i_rst = 1'b0; INSTR = 8'hB0;
    tick;
    repeat (4) tick;
    chk("perf_retired1", retired, er(1));
    INSTR = 8'h00; inEmpty = 1'b1;
    tick; tick; tick;
    chk("mid_decode_ctl", ctl, C_NONE);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_ctl", ctl, C_RST);
    chk("async_rst_retired", retired, 0);
    chk("async_rst_fault", fault, 0);
    inEmpty = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
